// File: rtl/cmp_mon_pkg.sv
// Shared types for the comparator window monitor: FSM states and sample class codes.
package cmp_mon_pkg;

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_e;

  typedef logic [1:0] cls_t;

  localparam cls_t CLS_GRT  = 2'd0;
  localparam cls_t CLS_LESS = 2'd1;
  localparam cls_t CLS_EQ   = 2'd2;
  localparam cls_t CLS_ERR  = 2'd3;

  // Only a strictly one-hot flag set is a legal comparator result.
  function automatic cls_t classify(input logic grt, input logic less, input logic eq);
    cls_t c;
    case ({grt, less, eq})
      3'b100:  c = CLS_GRT;
      3'b010:  c = CLS_LESS;
      3'b001:  c = CLS_EQ;
      default: c = CLS_ERR;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cmp_classify.sv
// Combinational decode of the comparator flags into a 2-bit class code.
module cmp_classify
  import cmp_mon_pkg::*;
(
  input  logic a_grt_b,
  input  logic a_less_b,
  input  logic a_eq_b,
  output cls_t cls_o
);

  assign cls_o = classify(a_grt_b, a_less_b, a_eq_b);

endmodule

// File: rtl/cmp_window_monitor.sv
// Windowed class counter for comparator flags with a valid/ready report port and
// an equal-run streak tracker.
module cmp_window_monitor
  import cmp_mon_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int WINDOW   = 16,
  parameter int LOCK_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a_grt_b,
  input  logic             a_less_b,
  input  logic             a_eq_b,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_grt_cnt,
  output logic [CNT_W-1:0] rpt_less_cnt,
  output logic [CNT_W-1:0] rpt_eq_cnt,
  output logic [CNT_W-1:0] rpt_err_cnt,
  output logic [CNT_W-1:0] streak,
  output logic             eq_lock
);

  if (WINDOW < 1 || WINDOW > (2**CNT_W) - 1) begin : g_bad_window
    $error("cmp_window_monitor: WINDOW out of range for CNT_W");
  end
  if (LOCK_LEN < 1 || LOCK_LEN > (2**CNT_W) - 1) begin : g_bad_lock
    $error("cmp_window_monitor: LOCK_LEN out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] STREAK_MAX = '1;
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] LOCK_THR   = CNT_W'(LOCK_LEN);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  state_e           state_q;
  logic             rpt_valid_q, eq_lock_q;
  logic [CNT_W-1:0] grt_q, less_q, eq_q, err_q, cnt_q;
  logic [CNT_W-1:0] grt_d, less_d, eq_d, err_d, cnt_d;
  logic [CNT_W-1:0] rpt_grt_q, rpt_less_q, rpt_eq_q, rpt_err_q;
  logic [CNT_W-1:0] streak_q, streak_d;
  cls_t             cls;
  logic             accept, win_close;

  cmp_classify u_classify (
    .a_grt_b  (a_grt_b),
    .a_less_b (a_less_b),
    .a_eq_b   (a_eq_b),
    .cls_o    (cls)
  );

  assign in_ready  = (state_q == ACCUM);
  assign accept    = in_valid & in_ready;
  assign win_close = accept & (cnt_q == LAST_IDX);

  always_comb begin
    grt_d    = grt_q;
    less_d   = less_q;
    eq_d     = eq_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    streak_d = streak_q;
    if (accept) begin
      cnt_d = cnt_q + ONE;
      case (cls)
        CLS_GRT:  grt_d  = grt_q + ONE;
        CLS_LESS: less_d = less_q + ONE;
        CLS_EQ:   eq_d   = eq_q + ONE;
        default:  err_d  = err_q + ONE;
      endcase
      // The streak spans window boundaries and saturates rather than wrapping.
      if (cls == CLS_EQ) begin
        if (streak_q != STREAK_MAX) streak_d = streak_q + ONE;
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      rpt_valid_q <= 1'b0;
      eq_lock_q   <= 1'b0;
      streak_q    <= '0;
      grt_q       <= '0;
      less_q      <= '0;
      eq_q        <= '0;
      err_q       <= '0;
      cnt_q       <= '0;
      rpt_grt_q   <= '0;
      rpt_less_q  <= '0;
      rpt_eq_q    <= '0;
      rpt_err_q   <= '0;
    end else begin
      streak_q  <= streak_d;
      eq_lock_q <= (streak_d >= LOCK_THR);
      case (state_q)
        ACCUM: begin
          if (win_close) begin
            // Report carries the totals including the closing sample.
            rpt_grt_q   <= grt_d;
            rpt_less_q  <= less_d;
            rpt_eq_q    <= eq_d;
            rpt_err_q   <= err_d;
            grt_q       <= '0;
            less_q      <= '0;
            eq_q        <= '0;
            err_q       <= '0;
            cnt_q       <= '0;
            rpt_valid_q <= 1'b1;
            state_q     <= REPORT;
          end else begin
            grt_q  <= grt_d;
            less_q <= less_d;
            eq_q   <= eq_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
          end
        end
        REPORT: begin
          if (rpt_ready) begin
            rpt_valid_q <= 1'b0;
            state_q     <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign rpt_valid    = rpt_valid_q;
  assign rpt_grt_cnt  = rpt_grt_q;
  assign rpt_less_cnt = rpt_less_q;
  assign rpt_eq_cnt   = rpt_eq_q;
  assign rpt_err_cnt  = rpt_err_q;
  assign streak       = streak_q;
  assign eq_lock      = eq_lock_q;

endmodule

// File: tb/tb_cmp_window_monitor.sv
// Directed bench for cmp_window_monitor with a reference model and report scoreboard.
module tb_cmp_window_monitor;

  localparam int CNT_W    = 8;
  localparam int WINDOW   = 16;
  localparam int LOCK_LEN = 4;
  localparam int SMAX     = 255;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic             a_grt_b, a_less_b, a_eq_b;
  logic             rpt_valid, rpt_ready;
  logic [CNT_W-1:0] rpt_grt_cnt, rpt_less_cnt, rpt_eq_cnt, rpt_err_cnt, streak;
  logic             eq_lock;

  cmp_window_monitor #(.CNT_W(CNT_W), .WINDOW(WINDOW), .LOCK_LEN(LOCK_LEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a_grt_b      (a_grt_b),
    .a_less_b     (a_less_b),
    .a_eq_b       (a_eq_b),
    .rpt_valid    (rpt_valid),
    .rpt_ready    (rpt_ready),
    .rpt_grt_cnt  (rpt_grt_cnt),
    .rpt_less_cnt (rpt_less_cnt),
    .rpt_eq_cnt   (rpt_eq_cnt),
    .rpt_err_cnt  (rpt_err_cnt),
    .streak       (streak),
    .eq_lock      (eq_lock)
  );

  always #5 clk = ~clk;

  typedef struct {
    int g;
    int l;
    int e;
    int r;
  } rpt_t;

  rpt_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   m_g, m_l, m_e, m_r, m_cnt, m_streak;
  bit   m_report;
  int   reports_exp = 0;
  int   dut_xfers = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic model_clear();
    m_g = 0; m_l = 0; m_e = 0; m_r = 0; m_cnt = 0; m_streak = 0; m_report = 0;
    reports_exp -= exp_q.size();
    exp_q.delete();
  endtask

  // One clock: drive, check outputs at the falling edge, advance the model.
  task automatic cyc(input bit v, input bit [2:0] f, input bit rdy);
    bit   acc;
    rpt_t r;
    in_valid = v;
    {a_grt_b, a_less_b, a_eq_b} = f;
    rpt_ready = rdy;
    @(negedge clk);
    chk("in_ready", in_ready, !m_report);
    chk("rpt_valid", rpt_valid, m_report);
    chk("streak", streak, m_streak);
    chk("eq_lock", eq_lock, m_streak >= LOCK_LEN);
    if (m_report && exp_q.size() > 0) begin
      chk("rpt_grt_cnt", rpt_grt_cnt, exp_q[0].g);
      chk("rpt_less_cnt", rpt_less_cnt, exp_q[0].l);
      chk("rpt_eq_cnt", rpt_eq_cnt, exp_q[0].e);
      chk("rpt_err_cnt", rpt_err_cnt, exp_q[0].r);
    end
    if (rpt_valid === 1'b1 && rdy) dut_xfers++;
    acc = v && !m_report;
    if (m_report && rdy) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      m_report = 0;
    end else if (acc) begin
      case (f)
        3'b100:  begin m_g++; m_streak = 0; end
        3'b010:  begin m_l++; m_streak = 0; end
        3'b001:  begin m_e++; if (m_streak < SMAX) m_streak++; end
        default: begin m_r++; m_streak = 0; end
      endcase
      m_cnt++;
      if (m_cnt == WINDOW) begin
        r.g = m_g; r.l = m_l; r.e = m_e; r.r = m_r;
        exp_q.push_back(r);
        reports_exp++;
        m_g = 0; m_l = 0; m_e = 0; m_r = 0; m_cnt = 0;
        m_report = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    {a_grt_b, a_less_b, a_eq_b} = 3'b001;
    rpt_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    model_clear();
    @(negedge clk);
    chk("rst_rpt_valid", rpt_valid, 0);
    chk("rst_eq_lock", eq_lock, 0);
    chk("rst_streak", streak, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_rpt_grt", rpt_grt_cnt, 0);
    chk("rst_rpt_less", rpt_less_cnt, 0);
    chk("rst_rpt_eq", rpt_eq_cnt, 0);
    chk("rst_rpt_err", rpt_err_cnt, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    rpt_ready = 1'b0;
    {a_grt_b, a_less_b, a_eq_b} = 3'b000;
    do_reset();

    // 1: 8 GRT, 4 LESS, 4 EQ with consumer always ready
    for (int i = 0; i < 8; i++) cyc(1, 3'b100, 1);
    for (int i = 0; i < 4; i++) cyc(1, 3'b010, 1);
    for (int i = 0; i < 4; i++) cyc(1, 3'b001, 1);
    for (int i = 0; i < 3; i++) cyc(0, 3'b000, 1);

    // 2: illegal flag patterns mixed into an EQ window
    for (int i = 0; i < 5; i++) cyc(1, 3'b001, 1);
    cyc(1, 3'b000, 1);
    for (int i = 0; i < 4; i++) cyc(1, 3'b001, 1);
    cyc(1, 3'b110, 1);
    for (int i = 0; i < 4; i++) cyc(1, 3'b001, 1);
    cyc(1, 3'b111, 1);
    cyc(0, 3'b000, 1);

    // 3: backpressure while samples keep arriving
    for (int i = 0; i < 16; i++) cyc(1, (i % 3 == 0) ? 3'b010 : 3'b100, 0);
    for (int i = 0; i < 5; i++) cyc(1, 3'b001, 0);
    cyc(1, 3'b001, 1);
    cyc(1, 3'b001, 1);

    // 4: lock after LOCK_LEN equal samples, cleared by GRT
    cyc(1, 3'b100, 1);
    for (int i = 0; i < 4; i++) cyc(1, 3'b001, 1);
    cyc(1, 3'b100, 1);
    cyc(0, 3'b000, 1);
    cyc(0, 3'b000, 1);

    // 5: reset mid-window and with a report pending
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1, 3'b001, 1);
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 3'b010, 0);
    cyc(0, 3'b000, 0);
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, (i < 6) ? 3'b100 : 3'b001, 1);
    cyc(0, 3'b000, 1);

    // 6: sparse valid, random flags and random consumer readiness
    for (int i = 0; i < 80; i++)
      cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 3; i++) cyc(0, 3'b000, 1);

    // 7: long EQ run saturates the streak
    for (int i = 0; i < 300; i++) cyc(1, 3'b001, 1);
    cyc(0, 3'b000, 1);

    chk("report_count", dut_xfers, reports_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
